instruction_memory_pipelined: RTL
=================================

Name: instruction_memory_pipelined

Overview:
Parametrised byte-addressed instruction memory with big-endian word assembly, a valid/ready fetch interface, and a configurable read pipeline of 1 or 2 stages. Adds a byte-enabled load port so the program can be written at run time without an initial block. Faults on misaligned or out-of-range fetches. Sits between the PC/fetch stage and the decode stage of the MIPS datapath.

Parameters:
ADDR_WIDTH, 8, width of byte address on fetch and load ports
DEPTH_BYTES, 512, number of byte locations in the array
WORD_BYTES, 4, bytes per instruction word; instruction width = 8*WORD_BYTES
READ_LATENCY, 1, number of registered stages from accepted fetch to instructionValid; legal values 1 or 2
INIT_FILE, "", hex file loaded with $readmemh at elaboration when non-empty; array otherwise uninitialised

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears pipeline state
fetchValid  input  1  fetch request present
fetchAddress  input  ADDR_WIDTH  byte address of instruction
fetchReady  output  1  request accepted this cycle when high with fetchValid
instructionValid  output  1  instructionOut/instructionFault hold a result
instructionOut  output  8*WORD_BYTES  assembled instruction, byte at address in MSBs
instructionFault  output  1  result is a faulted fetch
instructionReady  input  1  consumer takes result when high with instructionValid
loadEnable  input  1  write request on load port
loadAddress  input  ADDR_WIDTH  word-aligned byte address for write
loadData  input  8*WORD_BYTES  write data, big-endian as instructionOut
loadByteEnable  input  WORD_BYTES  per-byte write enable; bit WORD_BYTES-1 = byte at loadAddress

Behaviour:
- Reset (async, any time): all stage valid bits 0, instructionValid=0, instructionOut=0, instructionFault=0; in-flight fetches discarded; array contents retained.
- Pipeline: READ_LATENCY stages, each {valid, data, fault}. advance = !instructionValid || instructionReady. All stages shift together only when advance=1; otherwise every stage holds (no bubble collapsing).
- fetchReady = advance && !loadEnable. Accept = fetchValid && fetchReady; stage 1 valid <= accept on advance.
- Latency: accepted fetch in cycle N -> instructionValid in cycle N+READ_LATENCY when not stalled; stall cycles add 1:1. Throughput 1 word/cycle with instructionReady held high.
- Output stable: while instructionValid=1 and instructionReady=0, instructionOut/instructionFault must not change.
- Word assembly: instructionOut = {mem[A], mem[A+1], ..., mem[A+WORD_BYTES-1]}.
- Fault: A[log2(WORD_BYTES)-1:0] != 0 (misaligned) or A+WORD_BYTES > DEPTH_BYTES (out of range) -> instructionFault=1, instructionOut=0; no array read; address wrap never occurs.
- Load: when loadEnable=1, byte i written where loadByteEnable bit set, on posedge. Load has priority: fetch not accepted same cycle (fetchReady=0), pipeline still drains if advance. Misaligned or out-of-range loadAddress: write dropped silently.
- Read-after-write: a fetch accepted the cycle after a load returns the new bytes.
- loadEnable held continuously starves fetches; no fairness required.

Optional Feature:
IMEM_UNALIGNED_FETCH_EN: when defined, misaligned fetch is not a fault; returns the WORD_BYTES consecutive bytes starting at A (range check still applies, fault only if A+WORD_BYTES > DEPTH_BYTES). When undefined, misaligned fetch faults as above.

Test Plan:
- Load 0x8C220004 at addr 0x00, byte-enable 4'b1111; fetch 0x00 next cycle, READ_LATENCY=1 -> instructionValid one cycle later, instructionOut=0x8C220004, fault=0.
- Back-to-back fetches 0x00,0x04,0x08 with instructionReady=1 -> three consecutive valid results in address order, no gaps; repeat READ_LATENCY=2 -> first result one cycle later.
- Hold instructionReady=0 for 3 cycles with 2 fetches in flight -> fetchReady=0, instructionOut stable, both results delivered in order after release, none lost or duplicated.
- Fetch 0x02 (misaligned) -> fault=1, instructionOut=0; with IMEM_UNALIGNED_FETCH_EN -> fault=0, bytes 2..5. Fetch 0x1FE with DEPTH_BYTES=512 and ADDR_WIDTH=9 -> fault=1 in both builds.
- Byte-enable 4'b0010 load of 0xFFFFFFFF over word 0x8C220004 at 0x00 -> fetch returns 0x8C22FF04.
- Assert reset mid-stall with valid output -> instructionValid=0, instructionOut=0 immediately (async); after release fetch of loaded address returns pre-reset contents.

Source files
------------

// File: rtl/instruction_memory_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : instruction_memory_pipelined
// Brief    : Byte-addressed instruction memory with big-endian word fetch, a
//            1- or 2-stage valid/ready read pipeline and a byte-enabled load
//            port. Define IMEM_UNALIGNED_FETCH_EN to permit misaligned fetch.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_memory_pipelined #(
    parameter int    ADDR_WIDTH   = 8,
    parameter int    DEPTH_BYTES  = 512,
    parameter int    WORD_BYTES   = 4,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fetchValid,
    input  logic [ADDR_WIDTH-1:0]   fetchAddress,
    output logic                    fetchReady,
    output logic                    instructionValid,
    output logic [8*WORD_BYTES-1:0] instructionOut,
    output logic                    instructionFault,
    input  logic                    instructionReady,
    input  logic                    loadEnable,
    input  logic [ADDR_WIDTH-1:0]   loadAddress,
    input  logic [8*WORD_BYTES-1:0] loadData,
    input  logic [WORD_BYTES-1:0]   loadByteEnable
);

    localparam int          c_WORD_BITS = 8 * WORD_BYTES;
    localparam int          c_IDX_BITS  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [31:0] c_OFS_MASK  = 32'(WORD_BYTES - 1);
    localparam logic [31:0] c_WORD_SPAN = 32'(WORD_BYTES);
    localparam logic [31:0] c_DEPTH     = 32'(DEPTH_BYTES);

    logic [7:0]             r_mem [DEPTH_BYTES];
    logic [READ_LATENCY-1:0] r_valid;
    logic [READ_LATENCY-1:0] r_fault;
    logic [c_WORD_BITS-1:0] r_data [READ_LATENCY];

    logic                   w_advance;
    logic                   w_accept;
    logic                   w_fetch_misaligned;
    logic                   w_fetch_oor;
    logic                   w_fetch_fault;
    logic                   w_load_ok;
    logic [c_WORD_BITS-1:0] w_fetch_word;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign w_advance  = !instructionValid || instructionReady;
    assign fetchReady = w_advance && !loadEnable;
    assign w_accept   = fetchValid && fetchReady;

`ifdef IMEM_UNALIGNED_FETCH_EN
    assign w_fetch_misaligned = 1'b0;
`else
    assign w_fetch_misaligned = (32'(fetchAddress) & c_OFS_MASK) != 32'd0;
`endif
    assign w_fetch_oor   = (32'(fetchAddress) + c_WORD_SPAN) > c_DEPTH;
    assign w_fetch_fault = w_fetch_misaligned || w_fetch_oor;

    assign w_load_ok = loadEnable
                    && ((32'(loadAddress) & c_OFS_MASK) == 32'd0)
                    && ((32'(loadAddress) + c_WORD_SPAN) <= c_DEPTH);

    // Lowest address lands in the MSBs; faulted fetches never touch the array.
    always_comb begin
        w_fetch_word = '0;
        if (!w_fetch_fault) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                w_fetch_word[c_WORD_BITS-1-8*i -: 8] =
                    r_mem[c_IDX_BITS'(32'(fetchAddress) + 32'(i))];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_load_ok) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (loadByteEnable[WORD_BYTES-1-i]) begin
                    r_mem[c_IDX_BITS'(32'(loadAddress) + 32'(i))] <=
                        loadData[c_WORD_BITS-1-8*i -: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_fault <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_data[s] <= '0;
            end
        end else if (w_advance) begin
            r_valid[0] <= w_accept;
            r_fault[0] <= w_accept && w_fetch_fault;
            r_data[0]  <= w_accept ? w_fetch_word : '0;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_fault[s] <= r_fault[s-1];
                r_data[s]  <= r_data[s-1];
            end
        end
    end

    assign instructionValid = r_valid[READ_LATENCY-1];
    assign instructionFault = r_fault[READ_LATENCY-1];
    assign instructionOut   = r_data[READ_LATENCY-1];

endmodule
`default_nettype wire
